// File: rtl/prio_arb_pkg.sv
// prio_arb_pkg: shared state type, owner codes and grant-to-code mapping for prio_arb_sync
package prio_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_e;
  localparam logic [1:0] ID_REQ3 = 2'b00;
  localparam logic [1:0] ID_REQ2 = 2'b01;
  localparam logic [1:0] ID_REQ1 = 2'b10;
  localparam logic [1:0] ID_REQ0 = 2'b11;
  function automatic logic [1:0] gnt_code(input logic [3:0] oh);
    return oh[3] ? ID_REQ3 : oh[2] ? ID_REQ2 : oh[1] ? ID_REQ1 : oh[0] ? ID_REQ0 : 2'b00;
  endfunction
endpackage

// File: rtl/prio_pick.sv
// prio_pick: combinational winner select, fixed (bit 3 first) or downward search from start
module prio_pick import prio_arb_pkg::*; (
  input  logic [3:0] eff,
  input  logic [1:0] start,
  input  logic       rr_en,
  output logic [3:0] win_onehot,
  output logic [1:0] win_id,
  output logic       any
);
  logic [1:0] idx;
  // Later iterations overwrite earlier ones, so k=0 (start or bit 3) has top priority
  always_comb begin
    win_onehot = '0;
    idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_en ? start - 2'(k) : 2'(3 - k);
      if (eff[idx]) win_onehot = 4'b0001 << idx;
    end
  end
  assign win_id = gnt_code(win_onehot);
  assign any = |eff;
endmodule

// File: rtl/prio_arb_sync.sv
// prio_arb_sync: 4-requester arbiter with bounded tenure and fixed or round-robin priority
module prio_arb_sync import prio_arb_pkg::*; #(
  parameter int MAX_HOLD = 4,
  parameter bit RR_EN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);
  localparam int CW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  state_e        state_q;
  logic [3:0]    gnt_q, mask_q, eff_d, win_onehot;
  logic [1:0]    gnt_id_q, rr_ptr_q, win_id;
  logic [CW-1:0] hold_cnt_q;
  logic          preempt_q, any, timeout;
  // A requester masked after timeout still wins if nobody else is asking
  assign eff_d = |(req & ~mask_q) ? req & ~mask_q : req;
  assign timeout = MAX_HOLD != 0 && hold_cnt_q == CW'(MAX_HOLD - 1);
  prio_pick u_pick (
    .eff(eff_d),
    .start(rr_ptr_q),
    .rr_en(RR_EN),
    .win_onehot(win_onehot),
    .win_id(win_id),
    .any(any)
  );
  // Owner index is the bitwise inverse of its code, so o-1 is ~gnt_id_q - 1
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      preempt_q  <= 1'b0;
      hold_cnt_q <= '0;
      rr_ptr_q   <= 2'd3;
      mask_q     <= '0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        IDLE: if (any) begin
          state_q    <= GRANT;
          gnt_q      <= win_onehot;
          gnt_id_q   <= win_id;
          mask_q     <= '0;
          hold_cnt_q <= '0;
        end
        GRANT: if (!(|(req & gnt_q)) || timeout) begin
          state_q  <= IDLE;
          gnt_q    <= '0;
          gnt_id_q <= '0;
          rr_ptr_q <= ~gnt_id_q - 2'd1;
          if (|(req & gnt_q)) begin
            mask_q    <= gnt_q;
            preempt_q <= 1'b1;
          end
        end else hold_cnt_q <= hold_cnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt = gnt_q;
  assign gnt_id = gnt_id_q;
  assign gnt_valid = |gnt_q;
  assign preempt = preempt_q;
endmodule
